page_clean_out: RTL and testbench

Drain-side counterpart of the decompression page controller. Once `page_finish` reports that a page is fully decompressed into the 16 history BRAM banks, this block reads the page out in bank-interleaved order. It streams the data on a valid/ready output interface with byte keep and last markers, then pulses `cl_finish` so the controller can release the page and accept the next one.

---
 rtl/page_clean_out_pkg.sv | 30 +++
 rtl/page_clean_out_skid_fifo.sv | 48 ++++
 rtl/page_clean_out.sv | 148 ++++++++++++++
 tb/tb_page_clean_out.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/page_clean_out_pkg.sv
// Shared types and helpers for the page drain path.
// State encoding, default geometry and the last-beat keep mask.
package page_clean_out_pkg;

  localparam int NUM_BANK_D = 16;
  localparam int DATA_W_D   = 64;
  localparam int ADDR_W_D   = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_FLUSH,
    S_DONE,
    S_WAIT_LOW
  } state_t;

  // rem == 0 means the final beat is full
  function automatic logic [63:0] keep_from_rem(
    input logic [5:0] rem,
    input int         bytes
  );
    logic [63:0] m;
    if (rem == 6'd0)
      m = (bytes >= 64) ? '1 : ((64'd1 << bytes) - 64'd1);
    else
      m = (64'd1 << rem) - 64'd1;
    return m;
  endfunction

endpackage

// File: rtl/page_clean_out_skid_fifo.sv
// Show-ahead output FIFO holding {data, keep, last}.
// Writer guarantees it never pushes into a full buffer.
module out_skid_fifo #(
  parameter int W     = 73,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop,
  output logic [W-1:0]  o_data,
  output logic [CW-1:0] o_count,
  output logic          o_empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_count;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= nxt(r_wr);
      if (i_pop)  r_rd <= nxt(r_rd);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/page_clean_out.sv
// Drains a decompressed page from the banked history RAM as a keep/last stream.
// Define PAGE_CLEAN_CLR_EN to mirror every read as a clearing write.
module page_clean_out
  import page_clean_out_pkg::*;
#(
  parameter int NUM_BANK   = NUM_BANK_D,
  parameter int DATA_W     = DATA_W_D,
  parameter int ADDR_W     = ADDR_W_D,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       page_finish,
  input  logic [31:0]                page_len,
  output logic [NUM_BANK-1:0]        ram_rd_en,
  output logic [ADDR_W-1:0]          ram_rd_addr,
  input  logic [NUM_BANK*DATA_W-1:0] ram_rd_data,
  output logic [NUM_BANK-1:0]        ram_clr_en,
  output logic [ADDR_W-1:0]          ram_clr_addr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [DATA_W/8-1:0]        out_keep,
  output logic                       out_last,
  output logic                       cl_finish,
  output logic                       len_err
);
  localparam int BYTES = DATA_W / 8;
  localparam int BYW   = $clog2(BYTES);
  localparam int BB    = $clog2(NUM_BANK);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int FW    = DATA_W + BYTES + 1;
  localparam logic [31:0] CAP = 32'(NUM_BANK * (2 ** ADDR_W) * BYTES);

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_len;
  logic [31:0]       r_nb;
  logic [31:0]       r_beat;
  logic              r_len_err;
  logic              r_rd_vld;
  logic [BB-1:0]     r_rd_bank;
  logic [BYTES-1:0]  r_rd_keep;
  logic              r_rd_last;

  logic [31:0]       w_len;
  logic [31:0]       w_nb;
  logic              w_start;
  logic              w_issue;
  logic              w_last_rd;
  logic [BYTES-1:0]  w_keep;
  logic [DATA_W-1:0] w_word;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  logic              w_pop;
  logic [FW-1:0]     w_fifo_out;

  assign w_len   = (page_len > CAP) ? CAP : page_len;
  assign w_nb    = (w_len + 32'(BYTES - 1)) >> BYW;
  assign w_start = (r_state == S_IDLE) && page_finish;
  assign w_issue = (r_state == S_READ) &&
                   (int'(w_count) + int'(r_rd_vld) < FIFO_DEPTH);
  assign w_last_rd = w_issue && (r_beat == r_nb - 32'd1);
  assign w_keep  = BYTES'(keep_from_rem(6'(r_len % 32'(BYTES)), BYTES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cl_finish = 1'b0;
    unique case (r_state)
      S_IDLE:     if (page_finish) w_next = (w_nb == '0) ? S_DONE : S_READ;
      S_READ:     if (w_last_rd) w_next = S_FLUSH;
      S_FLUSH:    if (w_pop && out_last) w_next = S_DONE;
      S_DONE: begin
        cl_finish = 1'b1;
        w_next    = S_WAIT_LOW;
      end
      S_WAIT_LOW: if (!page_finish) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len     <= '0;
      r_nb      <= '0;
      r_beat    <= '0;
      r_len_err <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_bank <= '0;
      r_rd_keep <= '0;
      r_rd_last <= 1'b0;
    end else begin
      if (w_start) begin
        r_len  <= w_len;
        r_nb   <= w_nb;
        r_beat <= '0;
        if (page_len > CAP) r_len_err <= 1'b1;
      end else if (w_issue) begin
        r_beat <= r_beat + 32'd1;
      end
      r_rd_vld  <= w_issue;
      r_rd_bank <= r_beat[BB-1:0];
      r_rd_keep <= w_last_rd ? w_keep : '1;
      r_rd_last <= w_last_rd;
    end
  end

  assign ram_rd_en   = w_issue ? (NUM_BANK'(1) << r_beat[BB-1:0]) : '0;
  assign ram_rd_addr = w_issue ? r_beat[BB +: ADDR_W] : '0;
  assign w_word      = ram_rd_data[r_rd_bank * DATA_W +: DATA_W];

`ifdef PAGE_CLEAN_CLR_EN
  assign ram_clr_en   = ram_rd_en;
  assign ram_clr_addr = ram_rd_addr;
`else
  assign ram_clr_en   = '0;
  assign ram_clr_addr = '0;
`endif

  out_skid_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_rd_vld),
    .i_data  ({w_word, r_rd_keep, r_rd_last}),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  // gate the show-ahead word so idle outputs read as zero
  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;
  assign out_data  = out_valid ? w_fifo_out[FW-1 -: DATA_W] : '0;
  assign out_keep  = out_valid ? w_fifo_out[BYTES:1] : '0;
  assign out_last  = out_valid && w_fifo_out[0];
  assign len_err   = r_len_err;

endmodule

// File: tb/tb_page_clean_out.sv
// Scoreboard bench for page_clean_out with a banked RAM model.
// Expected beats are derived from page length and bank/address rules.
module tb_page_clean_out;
  localparam int NBK = 16;
  localparam int DW  = 64;
  localparam int AW  = 9;
  localparam int BY  = 8;
  localparam int FD  = 4;
  localparam int CAP = NBK * 512 * BY;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              page_finish = 1'b0;
  logic [31:0]       page_len = '0;
  logic [NBK-1:0]    ram_rd_en;
  logic [AW-1:0]     ram_rd_addr;
  logic [NBK*DW-1:0] ram_rd_data = '0;
  logic [NBK-1:0]    ram_clr_en;
  logic [AW-1:0]     ram_clr_addr;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_data;
  logic [BY-1:0]     out_keep;
  logic              out_last;
  logic              cl_finish;
  logic              len_err;

  page_clean_out dut (
    .clk          (clk),
    .rst          (rst),
    .page_finish  (page_finish),
    .page_len     (page_len),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .ram_clr_en   (ram_clr_en),
    .ram_clr_addr (ram_clr_addr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last),
    .cl_finish    (cl_finish),
    .len_err      (len_err)
  );

  logic [63:0] mem [NBK][512];
  beat_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rd_idx = 0;
  int n_acc = 0;
  int n_cl = 0;
  int n_valid = 0;
  int exp_cl_cyc = -100;
  int first_v = -1;
  int last_hs = -1;
  bit rnd_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [DW-1:0] pd;
  logic [BY-1:0] pk;
  logic pl;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // bank RAM: one-cycle read latency
  initial begin
    logic [NBK-1:0] pen;
    logic [AW-1:0]  pad;
    forever begin
      @(negedge clk);
      pen = ram_rd_en;
      pad = ram_rd_addr;
      @(posedge clk);
      #1;
      for (int k = 0; k < NBK; k++)
        if (pen[k]) ram_rd_data[k*DW +: DW] = mem[k][pad];
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd_ready ? 1'($urandom) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (out_valid) begin
        n_valid++;
        if (first_v < 0) first_v = cyc;
      end
      if (prev_stall)
        chk("hold", {out_valid, out_data, out_keep, out_last},
            {1'b1, pd, pk, pl});
      prev_stall = out_valid && !out_ready;
      pd = out_data;
      pk = out_keep;
      pl = out_last;
      if (|ram_rd_en) begin
        chk("rd_bank_addr", {31'd0, $onehot(ram_rd_en), ram_rd_en, ram_rd_addr},
            {31'd0, 1'b1, NBK'(1) << (rd_idx % NBK), AW'(rd_idx / NBK)});
        chk("credit", 128'(rd_idx - n_acc < FD), 128'(1));
`ifdef PAGE_CLEAN_CLR_EN
        chk("clr_mirror", {ram_clr_en, ram_clr_addr}, {ram_rd_en, ram_rd_addr});
`else
        chk("clr_off", {ram_clr_en, ram_clr_addr}, 128'(0));
`endif
        rd_idx++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_extra", 128'(1), 128'(0));
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("beat", {out_data, out_keep, out_last}, {e.d, e.k, e.l});
        end
        if (out_last) begin
          exp_cl_cyc = cyc + 1;
          last_hs = cyc;
        end
        n_acc++;
      end
      if (cl_finish) begin
        n_cl++;
        chk("cl_cycle", 128'(cyc), 128'(exp_cl_cyc));
      end
    end
  end

  task automatic load_page(input int len, input bit rnd, output int nb,
                           output int start);
    int l;
    int rem;
    beat_t b;
    l  = (len > CAP) ? CAP : len;
    nb = (l + BY - 1) / BY;
    rem = l % BY;
    for (int n = 0; n < nb; n++) begin
      b.d = mem[n % NBK][n / NBK];
      b.l = (n == nb - 1);
      b.k = (b.l && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      exp_q.push_back(b);
    end
    @(posedge clk);
    #2;
    rnd_ready  = rnd;
    rd_idx     = 0;
    n_acc      = 0;
    first_v    = -1;
    last_hs    = -1;
    exp_cl_cyc = -100;
    page_len   = 32'(len);
    page_finish = 1'b1;
    start = cyc;
    if (nb == 0) exp_cl_cyc = start + 1;
  endtask

  task automatic run_page(input int len, input bit rnd);
    int nb;
    int start;
    int ncl0;
    int nv0;
    ncl0 = n_cl;
    nv0  = n_valid;
    load_page(len, rnd, nb, start);
    for (int i = 0; i < nb * 8 + 100 && n_cl == ncl0; i++) @(posedge clk);
    chk("cl_seen", 128'(n_cl), 128'(ncl0 + 1));
    chk("drained", 128'(exp_q.size()), 128'(0));
    chk("beats", 128'(n_acc), 128'(nb));
    if (nb == 0) begin
      chk("no_valid", 128'(n_valid), 128'(nv0));
    end else if (!rnd) begin
      chk("first_valid", 128'(first_v - start), 128'(3));
      chk("last_beat", 128'(last_hs - start), 128'(nb + 2));
    end
    repeat (5) @(posedge clk);
    chk("no_retrig", 128'({n_cl, rd_idx}), 128'({ncl0 + 1, nb}));
    #2;
    page_finish = 1'b0;
    rnd_ready = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int nb;
    int start;
    int ncl0;
    for (int k = 0; k < NBK; k++)
      for (int a = 0; a < 512; a++)
        mem[k][a] = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {ram_rd_en, ram_rd_addr, ram_clr_en, ram_clr_addr, out_valid,
         out_data, out_keep, out_last, cl_finish, len_err}, 128'(0));
    @(posedge clk);
    #2;
    rst = 1'b0;

    run_page(64, 1'b0);
    run_page(1000, 1'b0);
    run_page(13, 1'b0);
    run_page(0, 1'b0);
    run_page(256, 1'b1);
    run_page(int'($urandom_range(1, 3000)), 1'b1);
    run_page(int'($urandom_range(1, 3000)), 1'b0);
    chk("len_err_clear", 128'(len_err), 128'(0));
    run_page(70000, 1'b0);
    chk("len_err_set", 128'(len_err), 128'(1));

    ncl0 = n_cl;
    load_page(512, 1'b0, nb, start);
    for (int i = 0; i < 100 && n_acc < 10; i++) @(posedge clk);
    chk("reach_beat10", 128'(n_acc >= 10), 128'(1));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midpage_rst",
        {ram_rd_en, ram_rd_addr, ram_clr_en, ram_clr_addr, out_valid,
         out_data, out_keep, out_last, cl_finish, len_err}, 128'(0));
    page_finish = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    chk("no_cl_after_rst", 128'(n_cl), 128'(ncl0));
    run_page(64, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
